// File: rtl/stream_mover_sched_pkg.sv
// Shared types for the stream mover scheduler: FSM state encoding and id sizing.
package stream_mover_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARMED,
        BUSY,
        DONE
    } sched_state_e;

    function automatic int id_width(int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate the request vector so the search
// starts after last_id, pick the lowest set bit, then rotate the index back.
module rr_arbiter
    import stream_mover_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_id,
    output logic [IW-1:0] grant_id,
    output logic          grant_valid
);

    logic [IW-1:0]  start_id;
    logic [IW-1:0]  offset;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rotated;
    logic [IW:0]    sum;

    always_comb begin
        start_id    = (int'(last_id) >= N - 1) ? '0 : last_id + 1'b1;
        req_dbl     = {req, req};
        rotated     = req_dbl[start_id +: N];
        grant_valid = |rotated;
        // Walk downwards so the lowest rotated position is the one that sticks.
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = IW'(k);
            end
        end
        sum      = {1'b0, start_id} + {1'b0, offset};
        grant_id = (int'(sum) >= N) ? IW'(int'(sum) - N) : sum[IW-1:0];
    end

endmodule

// File: rtl/stream_mover_scheduler.sv
// Shares one stream-to-NASTI mover among NREQ producers: grants one request at a
// time, issues its address, routes its stream, and reports completion by id.
module stream_mover_scheduler
    import stream_mover_sched_pkg::*;
#(
    parameter  int NREQ       = 4,
    parameter  int ADDR_WIDTH = 64,
    parameter  int DATA_WIDTH = 64,
    localparam int KW         = DATA_WIDTH / 8,
    localparam int IW         = id_width(NREQ)
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ-1:0][ADDR_WIDTH-1:0] req_addr,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ-1:0]                 in_t_valid,
    input  logic [NREQ-1:0]                 in_t_last,
    input  logic [NREQ-1:0][DATA_WIDTH-1:0] in_t_data,
    input  logic [NREQ-1:0][KW-1:0]         in_t_keep,
    input  logic [NREQ-1:0][KW-1:0]         in_t_strb,
    output logic [NREQ-1:0]                 in_t_ready,
    output logic                            m_t_valid,
    output logic                            m_t_last,
    output logic [DATA_WIDTH-1:0]           m_t_data,
    output logic [KW-1:0]                   m_t_keep,
    output logic [KW-1:0]                   m_t_strb,
    input  logic                            m_t_ready,
    output logic [ADDR_WIDTH-1:0]           r_dest,
    output logic                            r_valid,
    input  logic                            r_ready,
    output logic                            done_valid,
    output logic [IW-1:0]                   done_id,
    input  logic                            done_ready,
    output logic                            busy
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(KW - 1);

    sched_state_e  state;
    logic [IW-1:0] cur;
    logic [IW-1:0] last_id;
    logic [IW-1:0] grant_id;
    logic          grant_valid;
    logic          stream_active;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req         (req_valid),
        .last_id     (last_id),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_valid) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign stream_active = (state == ISSUE) || (state == ARMED) || (state == BUSY);
    assign busy          = (state != IDLE);

    // Only the granted producer is connected; everyone else sees ready low and stalls.
    always_comb begin
        m_t_valid  = 1'b0;
        m_t_last   = 1'b0;
        m_t_data   = '0;
        m_t_keep   = '0;
        m_t_strb   = '0;
        in_t_ready = '0;
        if (stream_active) begin
            m_t_valid       = in_t_valid[cur];
            m_t_last        = in_t_last[cur];
            m_t_data        = in_t_data[cur];
            m_t_keep        = in_t_keep[cur];
            m_t_strb        = in_t_strb[cur];
            in_t_ready[cur] = m_t_ready;
        end
    end

    // ARMED exists because the mover's r_ready is registered and still reads
    // high the cycle after it accepted the request; BUSY waits for it to rise again.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            cur        <= '0;
            last_id    <= IW'(NREQ - 1);
            r_dest     <= '0;
            r_valid    <= 1'b0;
            done_valid <= 1'b0;
            done_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cur     <= grant_id;
                        r_dest  <= req_addr[grant_id];
                        r_valid <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        state   <= ARMED;
                    end
                end
                ARMED: begin
                    state <= BUSY;
                end
                BUSY: begin
                    if (r_ready) begin
                        done_valid <= 1'b1;
                        done_id    <= cur;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        last_id    <= cur;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    addr_aligned_a: assert property (@(posedge aclk) disable iff (!aresetn)
        (state == IDLE && grant_valid) |-> ((req_addr[grant_id] & ALIGN_MASK) == '0));

endmodule

// File: tb/tb_stream_mover_scheduler.sv
// Directed bench for stream_mover_scheduler with a small mover and producer model
// driven cycle by cycle; outputs are sampled on the falling edge.
module tb_stream_mover_scheduler;

    localparam int NREQ = 4;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int KW   = DW / 8;
    localparam int IW   = 2;

    logic                    aclk = 1'b0;
    logic                    aresetn;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         in_t_valid;
    logic [NREQ-1:0]         in_t_last;
    logic [NREQ-1:0][DW-1:0] in_t_data;
    logic [NREQ-1:0][KW-1:0] in_t_keep;
    logic [NREQ-1:0][KW-1:0] in_t_strb;
    logic [NREQ-1:0]         in_t_ready;
    logic                    m_t_valid;
    logic                    m_t_last;
    logic [DW-1:0]           m_t_data;
    logic [KW-1:0]           m_t_keep;
    logic [KW-1:0]           m_t_strb;
    logic                    m_t_ready;
    logic [AW-1:0]           r_dest;
    logic                    r_valid;
    logic                    r_ready;
    logic                    done_valid;
    logic [IW-1:0]           done_id;
    logic                    done_ready;
    logic                    busy;

    stream_mover_scheduler #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .in_t_valid(in_t_valid), .in_t_last(in_t_last), .in_t_data(in_t_data),
        .in_t_keep(in_t_keep), .in_t_strb(in_t_strb), .in_t_ready(in_t_ready),
        .m_t_valid(m_t_valid), .m_t_last(m_t_last), .m_t_data(m_t_data),
        .m_t_keep(m_t_keep), .m_t_strb(m_t_strb), .m_t_ready(m_t_ready),
        .r_dest(r_dest), .r_valid(r_valid), .r_ready(r_ready),
        .done_valid(done_valid), .done_id(done_id), .done_ready(done_ready),
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc       = 0;
    int pkt_len[NREQ];
    int pkt_idx[NREQ];
    int pkts_left[NREQ];
    int grants_left[NREQ];
    int mv_st, mv_beats, mv_id;
    logic mv_ready, mv_block;
    int false_done = 0, bad_data = 0, stray_ready = 0;
    int grant_q[$], grant_cyc_q[$], done_q[$], done_cyc_q[$], beats_q[$];
    logic [AW-1:0] dest_q[$];
    int last_beat_cyc, done_rise_cyc;
    logic [NREQ-1:0] s_req_ready, s_in_t_ready;
    logic            s_r_valid, s_r_ready, s_done_valid, s_busy, s_m_t_valid, s_prev_done_valid;
    logic [AW-1:0]   s_r_dest;
    logic [IW-1:0]   s_done_id;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_streams();
        for (int i = 0; i < NREQ; i++) begin
            in_t_valid[i] = (pkts_left[i] > 0);
            in_t_data[i]  = {24'h0, 8'(i), 32'(pkt_idx[i])};
            in_t_last[i]  = (pkt_idx[i] == pkt_len[i] - 1);
            in_t_keep[i]  = '1;
            in_t_strb[i]  = '1;
        end
        r_ready   = mv_ready && !mv_block;
        m_t_ready = (mv_st == 2);
    endtask

    task automatic applyStimulus(input int id, input logic [AW-1:0] addr, input int npkts, input int len);
        req_valid[id]   = 1'b1;
        req_addr[id]    = addr;
        pkt_len[id]     = len;
        pkt_idx[id]     = 0;
        pkts_left[id]   = npkts;
        grants_left[id] = npkts;
        drive_streams();
    endtask

    task automatic reset_all();
        aresetn   = 1'b0;
        req_valid = '0;
        mv_st     = 0;
        mv_beats  = 0;
        mv_id     = 0;
        mv_ready  = 1'b1;
        mv_block  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pkts_left[i]   = 0;
            pkt_idx[i]     = 0;
            pkt_len[i]     = 0;
            grants_left[i] = 0;
        end
        drive_streams();
    endtask

    // One clock: snapshot at the falling edge, then advance the models after the rising edge.
    task automatic step();
        logic [NREQ-1:0] t_adv, t_grant;
        logic            t_rhs, t_beat, t_last, t_dhs;
        @(negedge aclk);
        s_req_ready  = req_ready;
        s_in_t_ready = in_t_ready;
        s_r_valid    = r_valid;
        s_r_ready    = r_ready;
        s_r_dest     = r_dest;
        s_done_valid = done_valid;
        s_done_id    = done_id;
        s_busy       = busy;
        s_m_t_valid  = m_t_valid;
        t_adv   = in_t_valid & in_t_ready;
        t_grant = req_valid & req_ready;
        t_rhs   = r_valid && r_ready;
        t_beat  = m_t_valid && m_t_ready;
        t_last  = m_t_last;
        t_dhs   = done_valid && done_ready;
        if (done_valid && !s_prev_done_valid) done_rise_cyc = cyc;
        if (done_valid && mv_st != 0) false_done++;
        for (int i = 0; i < NREQ; i++) begin
            if (in_t_ready[i] && (grant_q.size() == 0 || i != grant_q[$])) stray_ready++;
            if (t_grant[i]) begin
                grant_q.push_back(i);
                grant_cyc_q.push_back(cyc);
            end
        end
        if (t_rhs) dest_q.push_back(r_dest);
        if (t_beat && (m_t_data != {24'h0, 8'(mv_id), 32'(mv_beats)} || m_t_keep != '1 || m_t_strb != '1))
            bad_data++;
        if (t_dhs) begin
            done_q.push_back(int'(done_id));
            done_cyc_q.push_back(cyc);
        end
        s_prev_done_valid = done_valid;
        @(posedge aclk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (t_grant[i]) begin
                grants_left[i]--;
                if (grants_left[i] <= 0) req_valid[i] = 1'b0;
            end
            if (t_adv[i]) begin
                if (pkt_idx[i] == pkt_len[i] - 1) begin
                    pkt_idx[i] = 0;
                    pkts_left[i]--;
                end else begin
                    pkt_idx[i]++;
                end
            end
        end
        case (mv_st)
            0: if (t_rhs) begin
                mv_st    = 1;
                mv_beats = 0;
                mv_id    = grant_q[$];
            end
            1: begin
                mv_st    = 2;
                mv_ready = 1'b0;
            end
            default: if (t_beat) begin
                mv_beats++;
                if (t_last) begin
                    beats_q.push_back(mv_beats);
                    last_beat_cyc = cyc - 1;
                    mv_st    = 0;
                    mv_ready = 1'b1;
                end
            end
        endcase
        drive_streams();
    endtask

    task automatic run_until_done(input string tag, input int count, input int budget);
        int n     = 0;
        int start = done_q.size();
        while (done_q.size() < start + count && n < budget) begin
            step();
            n++;
        end
        checkOutput({tag, "_no_timeout"}, 64'(done_q.size() >= start + count), 64'd1);
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int g0, d0, n, err;
        done_ready        = 1'b1;
        req_addr          = '0;
        s_prev_done_valid = 1'b0;
        reset_all();
        repeat (3) @(posedge aclk);
        #1;
        step();
        checkOutput("rst_r_valid", 64'(s_r_valid), 64'd0);
        checkOutput("rst_r_dest", s_r_dest, 64'd0);
        checkOutput("rst_done_valid", 64'(s_done_valid), 64'd0);
        checkOutput("rst_busy", 64'(s_busy), 64'd0);
        checkOutput("rst_req_ready", 64'(s_req_ready), 64'd0);
        aresetn = 1'b1;

        $display("[TB] single request");
        applyStimulus(2, 64'h1000, 1, 4);
        step();
        checkOutput("t1_req_ready_c0", 64'(s_req_ready), 64'b0100);
        checkOutput("t1_r_valid_c0", 64'(s_r_valid), 64'd0);
        step();
        checkOutput("t1_r_hs_c1", 64'(s_r_valid && s_r_ready), 64'd1);
        checkOutput("t1_r_dest_c1", s_r_dest, 64'h1000);
        run_until_done("t1", 1, 60);
        checkOutput("t1_done_id", 64'(done_q[$]), 64'd2);
        checkOutput("t1_beats", 64'(beats_q[$]), 64'd4);
        checkOutput("t1_dest", dest_q[$], 64'h1000);
        checkOutput("t1_done_latency", 64'(done_rise_cyc), 64'(last_beat_cyc + 2));
        step();
        checkOutput("t1_busy_after", 64'(s_busy), 64'd0);

        $display("[TB] all four requesting");
        reset_all();
        step();
        aresetn = 1'b1;
        g0 = grant_q.size();
        d0 = done_q.size();
        applyStimulus(0, 64'h2000, 2, 2);
        applyStimulus(1, 64'h2100, 1, 2);
        applyStimulus(2, 64'h2200, 1, 2);
        applyStimulus(3, 64'h2300, 1, 2);
        run_until_done("t2", 5, 200);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("t2_grant%0d", k), 64'(grant_q[g0 + k]), 64'(exp_order[k]));
            checkOutput($sformatf("t2_done%0d", k), 64'(done_q[d0 + k]), 64'(exp_order[k]));
        end

        $display("[TB] mover stall in ISSUE");
        mv_block = 1'b1;
        applyStimulus(3, 64'h3000, 1, 1);
        step();
        checkOutput("t3_req_ready_c0", 64'(s_req_ready), 64'b1000);
        applyStimulus(0, 64'h3100, 1, 1);
        err = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (!s_r_valid || s_r_dest != 64'h3000 || s_req_ready != '0) err++;
        end
        checkOutput("t3_stall_hold", 64'(err), 64'd0);
        mv_block = 1'b0;
        drive_streams();
        run_until_done("t3", 2, 80);
        checkOutput("t3_done_a", 64'(done_q[done_q.size() - 2]), 64'd3);
        checkOutput("t3_done_b", 64'(done_q[$]), 64'd0);
        checkOutput("t3_dest_a", dest_q[dest_q.size() - 2], 64'h3000);

        $display("[TB] ARMED with stale r_ready");
        applyStimulus(1, 64'h4000, 1, 3);
        step();
        step();
        step();
        checkOutput("t4_armed_r_ready", 64'(s_r_ready), 64'd1);
        checkOutput("t4_armed_done", 64'(s_done_valid), 64'd0);
        checkOutput("t4_armed_busy", 64'(s_busy), 64'd1);
        step();
        checkOutput("t4_busy_done", 64'(s_done_valid), 64'd0);
        run_until_done("t4", 1, 60);
        checkOutput("t4_done_id", 64'(done_q[$]), 64'd1);
        checkOutput("t4_beats", 64'(beats_q[$]), 64'd3);

        $display("[TB] done backpressure");
        done_ready = 1'b0;
        applyStimulus(0, 64'h5000, 1, 2);
        n = 0;
        do begin
            step();
            n++;
        end while (!s_done_valid && n < 60);
        checkOutput("t5_done_seen", 64'(s_done_valid), 64'd1);
        applyStimulus(1, 64'h5100, 1, 2);
        err = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (!s_done_valid || s_done_id != 2'd0 || s_req_ready != '0) err++;
        end
        checkOutput("t5_hold", 64'(err), 64'd0);
        done_ready = 1'b1;
        step();
        checkOutput("t5_done_hs_id", 64'(done_q[$]), 64'd0);
        step();
        checkOutput("t5_grant_next", 64'(s_req_ready), 64'b0010);
        checkOutput("t5_grant_cycle", 64'(grant_cyc_q[$]), 64'(done_cyc_q[$] + 1));
        run_until_done("t5", 1, 60);
        checkOutput("t5_done_id", 64'(done_q[$]), 64'd1);

        $display("[TB] reset mid-BUSY");
        applyStimulus(1, 64'h8000, 1, 8);
        n = 0;
        while (!(mv_st == 2 && mv_beats == 2) && n < 60) begin
            step();
            n++;
        end
        checkOutput("t6_two_beats", 64'(mv_beats), 64'd2);
        reset_all();
        step();
        checkOutput("t6_r_valid", 64'(s_r_valid), 64'd0);
        checkOutput("t6_r_dest", s_r_dest, 64'd0);
        checkOutput("t6_done_valid", 64'(s_done_valid), 64'd0);
        checkOutput("t6_done_id", 64'(s_done_id), 64'd0);
        checkOutput("t6_busy", 64'(s_busy), 64'd0);
        checkOutput("t6_m_t_valid", 64'(s_m_t_valid), 64'd0);
        checkOutput("t6_in_t_ready", 64'(s_in_t_ready), 64'd0);
        aresetn = 1'b1;
        step();
        applyStimulus(2, 64'h9000, 1, 3);
        run_until_done("t6", 1, 60);
        checkOutput("t6_fresh_id", 64'(done_q[$]), 64'd2);
        checkOutput("t6_fresh_beats", 64'(beats_q[$]), 64'd3);
        checkOutput("t6_fresh_dest", dest_q[$], 64'h9000);

        checkOutput("no_false_done", 64'(false_done), 64'd0);
        checkOutput("no_bad_data", 64'(bad_data), 64'd0);
        checkOutput("no_stray_ready", 64'(stray_ready), 64'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/stream_mover_scheduler.md
# stream_mover_scheduler

Round-robin scheduler that shares one stream-to-NASTI data mover among NREQ independent stream producers. Each producer posts a destination address. The scheduler grants one producer at a time and issues the address on the mover's request handshake. It routes only that producer's stream into the mover until the mover signals completion, then reports completion with the producer's id. It sits between the producer streams and the mover's `src` stream and `r_dest`/`r_valid`/`r_ready` request port.

## Interface
- `NREQ`, 4: number of requesters (2..16).
- `ADDR_WIDTH`, 64: destination address width.
- `DATA_WIDTH`, 64: stream data width; `KW = DATA_WIDTH/8`.

Ports (reset aresetn, asynchronous, active-low; clock aclk):
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `req_valid` in NREQ: requester i has a pending transfer.
- `req_addr` in NREQ×ADDR_WIDTH: destination of requester i, DATA_WIDTH/8-aligned.
- `req_ready` out NREQ: one-hot accept of the request.
- `in_t_valid`, `in_t_last` in NREQ: producer stream controls.
- `in_t_data` in NREQ×DATA_WIDTH: producer stream data.
- `in_t_keep`, `in_t_strb` in NREQ×KW: producer byte qualifiers.
- `in_t_ready` out NREQ: producer stream ready.
- `m_t_valid`, `m_t_last` out 1; `m_t_data` out DATA_WIDTH; `m_t_keep`, `m_t_strb` out KW: stream to mover `src`.
- `m_t_ready` in 1: mover `src.t_ready`.
- `r_dest` out ADDR_WIDTH; `r_valid` out 1; `r_ready` in 1: mover request port.
- `done_valid` out 1; `done_id` out $clog2(NREQ); `done_ready` in 1: completion report.
- `busy` out 1: high in any state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, ARMED, BUSY, DONE.
- **IDLE**
  - The arbiter picks a grant from `req_valid`, searching from `last+1` modulo NREQ.
  - `req_ready[g]` is combinational and equals IDLE && grant==g.
  - On the handshake: latch `cur=g` and `r_dest=req_addr[g]`, then go to ISSUE.
- **ISSUE**
  - `r_valid=1`.
  - When `r_valid && r_ready`, clear `r_valid` and go to ARMED.
- **ARMED**
  - Lasts exactly one cycle and ignores `r_ready`. The mover's `r_ready` is registered and is still high in this cycle.
  - Go to BUSY.
- **BUSY**
  - Wait for `r_ready==1`; this marks mover completion.
  - On completion, set `done_valid=1`, `done_id=cur`, and go to DONE.
- **DONE**
  - Hold `done_valid`/`done_id` until `done_ready`.
  - Then clear `done_valid`, set `last=cur`, and return to IDLE.
- **Stream mux** (combinational, active in ISSUE/ARMED/BUSY)
  - `m_t_*` = `in_t_*[cur]`.
  - `in_t_ready[i]` = active && i==cur && `m_t_ready`.
  - When inactive: `m_t_valid=0`; every `in_t_ready` is 0; `m_t_data`/`m_t_keep`/`m_t_strb`/`m_t_last` are don't-care and driven 0.
- A non-granted producer never sees `in_t_ready=1`. Its beats are stalled, never dropped.
- Unaligned `req_addr`: the address is forwarded unchanged. A simulation assertion fires.

## Timing
- **Reset values:** state IDLE; `r_valid=0`; `r_dest=0`; `done_valid=0`; `done_id=0`; `last=NREQ-1` (so the first search starts at requester 0); `busy=0`.
- **Request latency:** `req_valid` high in IDLE with `r_ready=1` produces the `req_ready` pulse in cycle 0, `r_valid` in cycle 1, and the request handshake in cycle 1.
- **Completion latency:** `done_valid` is asserted the cycle after `r_ready` rises in BUSY.
- **Back-to-back:** IDLE is re-entered the cycle after the `done_valid && done_ready` handshake. The next grant can be accepted in that same cycle.
- `req_valid` deasserting in IDLE before the grant is legal; there is no stickiness.
- Requesters must hold `req_valid` and `req_addr` until `req_ready`.
- If `r_ready` is low in ISSUE (mover still busy from outside use), hold `r_valid` with `r_dest` stable.
- Reset mid-operation: all state returns to reset values immediately and any partial packet is abandoned. The bench resets the mover together with this block.
- Fairness: a continuously requesting producer waits at most NREQ-1 transfers.

## Structure
- Package `stream_mover_sched_pkg`: state enum `sched_state_e {IDLE, ISSUE, ARMED, BUSY, DONE}`, and `function automatic id_width(int n)` returning `$clog2(n)`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]`, `last_id`.
  - Outputs: `grant_id`, `grant_valid`.
  - Purely combinational rotate–priority-encode–unrotate.
- The FSM, mux and registers live in `stream_mover_scheduler`.

## Test plan
1. **Single request.** Requester 2 posts addr 0x1000 and a 4-beat packet with last on beat 4; the mover model completes. Required: `r_dest=0x1000` handshake; exactly 4 beats on `m_t`; `done_id=2`; `busy` returns to 0.
2. **All four request simultaneously** after reset. Required: grant order 0,1,2,3, then 0 again if still requesting; `done_id` sequence matches.
3. **Mover stalls.** Hold `r_ready=0` for 10 cycles in ISSUE. Required: `r_valid` stays 1 and `r_dest` stays stable; no `req_ready` is issued.
4. **ARMED ignores stale `r_ready`.** The mover drops `r_ready` one cycle after the handshake. Required: no false `done_valid` in ARMED.
5. **Backpressure.** Hold `done_ready=0` for 5 cycles; requester 1 is pending meanwhile. Required: `done_valid`/`done_id` held; requester 1 is not granted until the done handshake, then granted the next cycle.
6. **Reset mid-BUSY** after 2 of 8 beats. Required: all outputs at reset values the cycle after reset assertion; a fresh request then completes normally.
